// File: rtl/scsi_buf_target.sv
// SCSI target that executes TEST UNIT READY, READ and WRITE against an external
// 256-byte synchronous buffer, running the REQ/ACK handshake one byte at a time.
module scsi_buf_target #(
  parameter int ID = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rst,
  input  logic       sel,
  input  logic       atn,
  input  logic       ack,
  input  logic [7:0] din,
  output logic       bsy,
  output logic       msg,
  output logic       cd,
  output logic       io,
  output logic       req,
  output logic [7:0] dout,
  output logic [7:0] buf_addr,
  input  logic [7:0] buf_rdata,
  output logic [7:0] buf_wdata,
  output logic       buf_we
);

  localparam logic [2:0] ID_BIT = 3'(ID);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SELECTED = 3'd1;
  localparam logic [2:0] S_COMMAND  = 3'd2;
  localparam logic [2:0] S_DATA_IN  = 3'd3;
  localparam logic [2:0] S_DATA_OUT = 3'd4;
  localparam logic [2:0] S_STATUS   = 3'd5;
  localparam logic [2:0] S_MSG_IN   = 3'd6;
  localparam logic [2:0] S_RELEASE  = 3'd7;

  // Per-byte handshake steps; PREP gives the buffer a cycle to return read data.
  localparam logic [2:0] HS_PREP = 3'd0;
  localparam logic [2:0] HS_LOAD = 3'd1;
  localparam logic [2:0] HS_PRES = 3'd2;
  localparam logic [2:0] HS_ACK  = 3'd3;
  localparam logic [2:0] HS_NACK = 3'd4;

  logic [2:0] state;
  logic [2:0] hs;
  logic [7:0] byte_cnt;
  logic [7:0] cdb [0:5];
  logic [7:0] status_byte;
  logic       armed;

  logic [7:0] tx_byte;
  logic [2:0] cmd_next;
  logic [7:0] cmd_status;
  logic       last_data;
  logic       atn_unused;

  assign atn_unused = atn;

  // A length byte of zero wraps to 255 here, giving a 256-byte transfer.
  assign last_data = (byte_cnt == cdb[4] - 8'd1);

  always_comb begin
    // NOTE: every combinational output gets a default before the case so no path
    // leaves it unassigned and no latch is inferred.
    {msg, cd, io} = 3'b000;
    case (state)
      S_COMMAND: {msg, cd, io} = 3'b010;
      S_DATA_IN: {msg, cd, io} = 3'b001;
      S_STATUS:  {msg, cd, io} = 3'b011;
      S_MSG_IN:  {msg, cd, io} = 3'b111;
      default:   ;
    endcase
  end

  always_comb begin
    tx_byte = 8'h00;
    case (state)
      S_DATA_IN: tx_byte = buf_rdata;
      S_STATUS:  tx_byte = status_byte;
      default:   ;
    endcase
  end

  always_comb begin
    cmd_next   = S_STATUS;
    cmd_status = 8'h02;
    case (cdb[0])
      8'h00: cmd_status = 8'h00;
      8'h08: begin cmd_next = S_DATA_IN;  cmd_status = 8'h00; end
      8'h0A: begin cmd_next = S_DATA_OUT; cmd_status = 8'h00; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      hs          <= HS_PREP;
      byte_cnt    <= 8'h00;
      status_byte <= 8'h00;
      armed       <= 1'b0;
      bsy         <= 1'b0;
      req         <= 1'b0;
      dout        <= 8'h00;
      buf_addr    <= 8'h00;
      buf_wdata   <= 8'h00;
      buf_we      <= 1'b0;
      // NOTE: cdb is six bytes of control state, not a data memory, so it is
      // cleared together with the other registers.
      for (int i = 0; i < 6; i++) cdb[i] <= 8'h00;
    end else if (rst) begin
      state     <= S_IDLE;
      hs        <= HS_PREP;
      byte_cnt  <= 8'h00;
      armed     <= 1'b1;
      bsy       <= 1'b0;
      req       <= 1'b0;
      dout      <= 8'h00;
      buf_addr  <= 8'h00;
      buf_wdata <= 8'h00;
      buf_we    <= 1'b0;
    end else begin
      // NOTE: state updates use non-blocking assignments so every branch sees
      // the register values from before this edge.
      armed  <= 1'b1;
      buf_we <= 1'b0;
      case (state)
        S_IDLE: begin
          // Selection is held off for the first clock after reset release.
          if (armed && sel && din[ID_BIT]) begin
            state <= S_SELECTED;
            bsy   <= 1'b1;
          end
        end
        S_SELECTED: begin
          if (!sel) begin
            state    <= S_COMMAND;
            hs       <= HS_PREP;
            byte_cnt <= 8'h00;
            buf_addr <= 8'h00;
          end
        end
        S_RELEASE: begin
          if (!ack) begin
            state <= S_IDLE;
            bsy   <= 1'b0;
          end
        end
        default: begin
          case (hs)
            HS_PREP: hs <= HS_LOAD;
            HS_LOAD: begin
              dout <= tx_byte;
              hs   <= HS_PRES;
            end
            HS_PRES: begin
              req <= 1'b1;
              hs  <= HS_ACK;
            end
            HS_ACK: begin
              if (ack) begin
                req <= 1'b0;
                hs  <= HS_NACK;
                if (state == S_COMMAND) cdb[byte_cnt[2:0]] <= din;
                if (state == S_DATA_OUT) begin
                  buf_wdata <= din;
                  buf_we    <= 1'b1;
                end
              end
            end
            HS_NACK: begin
              if (!ack) begin
                dout     <= 8'h00;
                hs       <= HS_PREP;
                byte_cnt <= byte_cnt + 8'd1;
                case (state)
                  S_COMMAND: begin
                    if (byte_cnt == 8'd5) begin
                      state       <= cmd_next;
                      status_byte <= cmd_status;
                      byte_cnt    <= 8'h00;
                    end
                  end
                  S_DATA_IN, S_DATA_OUT: begin
                    buf_addr <= buf_addr + 8'd1;
                    if (last_data) begin
                      state    <= S_STATUS;
                      byte_cnt <= 8'h00;
                    end
                  end
                  S_STATUS: state <= S_MSG_IN;
                  default:  state <= S_RELEASE;
                endcase
              end
            end
            default: hs <= HS_PREP;
          endcase
        end
      endcase
    end
  end

endmodule

// File: doc/scsi_buf_target.md
SCSI_BUF_TARGET -- requirements
Module: scsi_buf_target

Interface
REQ-001 SHALL have parameter ID, default 3, SCSI bus ID (0..7) to which this target responds.
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port rst  input  1  SCSI bus RST from initiator; synchronous abort.
REQ-005 SHALL have port sel  input  1  SCSI SEL from initiator.
REQ-006 SHALL have port atn  input  1  SCSI ATN; sampled but ignored.
REQ-007 SHALL have port ack  input  1  SCSI ACK from initiator.
REQ-008 SHALL have port din  input  8  initiator data bus: selection ID bits and data-out bytes.
REQ-009 SHALL have port bsy  output  1  target BSY.
REQ-010 SHALL have port msg, cd, io  output  1 each  phase lines.
REQ-011 SHALL have port req  output  1  target REQ.
REQ-012 SHALL have port dout  output  8  target data to initiator.
REQ-013 SHALL have port buf_addr  output  8  byte address into external 256-byte buffer.
REQ-014 SHALL have port buf_rdata  input  8  buffer read data, valid one clk after buf_addr changes.
REQ-015 SHALL have port buf_wdata  output  8  buffer write data.
REQ-016 SHALL have port buf_we  output  1  one-clk buffer write strobe.

Function
REQ-017 SHALL implement states IDLE, SELECTED, COMMAND, DATA_IN, DATA_OUT, STATUS, MSG_IN, RELEASE.
REQ-018 SHALL drive phase lines {msg,cd,io}: COMMAND 010, DATA_OUT 000, DATA_IN 001, STATUS 011, MSG_IN 111; IDLE/SELECTED/RELEASE 000.
REQ-019 IDLE: when sel=1 and din[ID]=1 -> SELECTED next clk with bsy=1; sel=1 with din[ID]=0 ignored.
REQ-020 SELECTED: hold bsy=1, wait sel=0, then enter COMMAND.
REQ-021 Byte handshake: set phase and dout, then req=1 no earlier than one clk later; wait ack=1; data-out bytes latch din on the clk ack is first sampled high; req=0 next clk; wait ack=0 before the next byte or phase change.
REQ-022 COMMAND: receive exactly 6 CDB bytes into cdb[0..5]; byte n is handshake n.
REQ-023 Transfer length LEN = cdb[4], with 0 meaning 256; buf_addr starts at 0 and increments by 1 per byte, wrapping 8 bits.
REQ-024 Opcode 0x00 (TEST UNIT READY): go to STATUS, status 0x00.
REQ-025 Opcode 0x08 (READ): DATA_IN of LEN bytes; dout = buf_rdata for current buf_addr; req only after rdata valid (REQ-014).
REQ-026 Opcode 0x0A (WRITE): DATA_OUT of LEN bytes; each latched byte -> buf_wdata with one-clk buf_we at current buf_addr, then addr increments.
REQ-027 Any other opcode: skip data, status 0x02 (CHECK CONDITION).
REQ-028 After data phase: STATUS with 1 byte, then MSG_IN with byte 0x00 (COMMAND COMPLETE), then RELEASE.
REQ-029 RELEASE: wait ack=0, drop bsy and all phase lines, return to IDLE; reselectable next clk.
REQ-030 rst=1 in any state: next clk IDLE, bsy=req=msg=cd=io=0, buf_we=0; cdb contents don't-care.
REQ-031 sel=1 while not IDLE SHALL be ignored.
REQ-032 buf_we SHALL never assert outside DATA_OUT; at most once per byte.
REQ-033 dout SHALL be 0x00 whenever io=0.

Reset
REQ-034 On reset: state IDLE; bsy, req, msg, cd, io, buf_we = 0; dout = 0x00; buf_addr = 0x00; buf_wdata = 0x00; cdb cleared.
REQ-035 Reset deassertion SHALL not assert any output in the following clk.

Verification
REQ-036 Select ID=3 (din=0x08, sel pulse), CDB 00 00 00 00 00 00 -> STATUS byte 0x00, MSG_IN 0x00, bsy drops, IDLE.
REQ-037 Buffer preloaded addr=value; CDB 08 00 00 00 04 00 -> DATA_IN bytes 00 01 02 03, status 0x00, message 0x00.
REQ-038 CDB 0A 00 00 00 03 00, data AA 55 C3 -> buf_we pulses at addr 0,1,2 with AA,55,C3; status 0x00.
REQ-039 CDB 08 .. cdb[4]=00 -> exactly 256 DATA_IN bytes, final buf_addr wraps to 0x00; opcode 0x25 -> no data, status 0x02.
REQ-040 din=0x04 with sel -> no bsy; rst=1 during DATA_IN byte 2 -> all outputs 0 next clk, subsequent select of ID 3 succeeds.
